// File: rtl/quadrant_scheduler.sv
// Quadrant scheduler: arbitrates four row producers (A..D) for the shared 4:1
// quadrant row encoder, holds the select stable while the mux settles, captures
// the row and offers it downstream with a valid/ready handshake.
// Optional build macro QUADRANT_SCHED_FIXED_PRIORITY_EN: lowest-index requester
// always wins (A highest); otherwise round-robin after the last grant.
module quadrant_scheduler #(
    parameter int unsigned WIDTH         = 105,
    parameter int unsigned SETTLE_CYCLES = 2    // legal range 1..15
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [3:0]       ack,
    output logic [1:0]       quadrant_sel,
    input  logic [WIDTH-1:0] row_in,
    output logic [WIDTH-1:0] row_out,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } stateE;

    // Counter loads SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges after the grant edge.
    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    stateE      state;
    logic [3:0] settleCnt;
    logic [1:0] grantNext;

`ifdef QUADRANT_SCHED_FIXED_PRIORITY_EN
    // Fixed priority: lowest-index set bit of req wins.
    always_comb begin
        grantNext = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                grantNext = 2'(i);
            end
        end
    end
`else
    logic [1:0] lastGrant;
    logic [1:0] scanIdx;
    logic       found;

    // Round-robin: first set bit scanning lastGrant+1 .. lastGrant+4 (mod 4).
    always_comb begin
        grantNext = lastGrant;
        scanIdx   = lastGrant;
        found     = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            scanIdx = lastGrant + 2'(i);
            if (!found && req[scanIdx]) begin
                grantNext = scanIdx;
                found     = 1'b1;
            end
        end
    end

    // Remember the quadrant whose row was just consumed; reset to D so A goes first.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            lastGrant <= 2'd3;
        end else if (state == StHold && row_valid && row_ready) begin
            lastGrant <= quadrant_sel;
        end
    end
`endif

    // Transaction FSM with registered select, row, handshake, ack and busy outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            settleCnt    <= 4'd0;
            quadrant_sel <= 2'd0;
            row_out      <= '0;
            row_valid    <= 1'b0;
            ack          <= 4'b0000;
            busy         <= 1'b0;
        end else begin
            ack <= 4'b0000;
            unique case (state)
                StIdle: begin
                    if (req != 4'b0000) begin
                        quadrant_sel <= grantNext;
                        settleCnt    <= CntInit;
                        busy         <= 1'b1;
                        state        <= StSettle;
                    end
                end
                StSettle: begin
                    if (settleCnt == 4'd0) begin
                        row_out   <= row_in;
                        row_valid <= 1'b1;
                        ack       <= 4'b0001 << quadrant_sel;
                        state     <= StHold;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                StHold: begin
                    if (row_valid && row_ready) begin
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    row_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quadrant_scheduler.sv
// Directed self-checking bench for quadrant_scheduler. A second instance built
// with SETTLE_CYCLES=1 covers the minimum settle latency. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_quadrant_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   ack;
    logic [1:0]   quadrantSel;
    logic [104:0] rowIn;
    logic [104:0] rowOut;
    logic         rowValid;
    logic         rowReady;
    logic         busy;

    logic [3:0]   req1;
    logic [3:0]   ack1;
    logic [1:0]   quadrantSel1;
    logic [104:0] rowIn1;
    logic [104:0] rowOut1;
    logic         rowValid1;
    logic         rowReady1;
    logic         busy1;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    quadrant_scheduler #(.WIDTH(105), .SETTLE_CYCLES(2)) dut (
        .clk_in      (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .quadrant_sel(quadrantSel),
        .row_in      (rowIn),
        .row_out     (rowOut),
        .row_valid   (rowValid),
        .row_ready   (rowReady),
        .busy        (busy)
    );

    quadrant_scheduler #(.WIDTH(105), .SETTLE_CYCLES(1)) dut1 (
        .clk_in      (clk),
        .rst         (rst),
        .req         (req1),
        .ack         (ack1),
        .quadrant_sel(quadrantSel1),
        .row_in      (rowIn1),
        .row_out     (rowOut1),
        .row_valid   (rowValid1),
        .row_ready   (rowReady1),
        .busy        (busy1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]   expSel;
        logic [104:0] heldRow;

        rst = 1'b1; req = 4'b0000; rowIn = '0; rowReady = 1'b0;
        req1 = 4'b0000; rowIn1 = '0; rowReady1 = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_ack",   128'(ack),         128'(4'b0000));
        check("rst_sel",   128'(quadrantSel), 128'(2'd0));
        check("rst_row",   128'(rowOut),      128'(0));
        check("rst_valid", 128'(rowValid),    128'(1'b0));
        check("rst_busy",  128'(busy),        128'(1'b0));
        rst = 1'b0;
        tick();

        // Round-robin with all four requesting: A,B,C,D,A,B,C,D (fixed priority: A always)
        req = 4'b1111; rowReady = 1'b1;
        for (int t = 0; t < 8; t++) begin
`ifdef QUADRANT_SCHED_FIXED_PRIORITY_EN
            expSel = 2'd0;
`else
            expSel = 2'(t);
`endif
            rowIn = 105'(t + 16);
            tick();
            check("rr_sel",   128'(quadrantSel), 128'(expSel));
            check("rr_busy",  128'(busy),        128'(1'b1));
            tick();
            check("rr_wait",  128'(rowValid),    128'(1'b0));
            tick();
            check("rr_ack",   128'(ack),         128'(4'b0001 << expSel));
            check("rr_row",   128'(rowOut),      128'(t + 16));
            tick();
            check("rr_done",  128'(rowValid),    128'(1'b0));
        end
        req = 4'b0000;
        tick();

        // Single request from C
        req = 4'b0100; rowIn = 105'h1ABC; rowReady = 1'b1;
        tick();
        check("single_sel",   128'(quadrantSel), 128'(2'd2));
        check("single_ack0",  128'(ack),         128'(4'b0000));
        tick();
        check("single_vld1",  128'(rowValid),    128'(1'b0));
        tick();
        check("single_vld2",  128'(rowValid),    128'(1'b1));
        check("single_ack",   128'(ack),         128'(4'b0100));
        check("single_row",   128'(rowOut),      128'(105'h1ABC));
        req = 4'b0000;
        tick();
        check("single_busy",  128'(busy),        128'(1'b0));
        check("single_vld3",  128'(rowValid),    128'(1'b0));
        check("single_ackx",  128'(ack),         128'(4'b0000));
        tick();

        // Backpressure: B captured, consumer stalls 10 cycles while row_in changes
        req = 4'b0010; rowReady = 1'b0; rowIn = 105'h1_2345_6789_ABCD;
        heldRow = 105'h1_2345_6789_ABCD;
        tick();
        tick();
        tick();
        check("bp_ack",  128'(ack),    128'(4'b0010));
        check("bp_row",  128'(rowOut), 128'(heldRow));
        req = 4'b0000; rowIn = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_vld", 128'(rowValid),    128'(1'b1));
            check("bp_hold_ack", 128'(ack),         128'(4'b0000));
            check("bp_hold_row", 128'(rowOut),      128'(heldRow));
            check("bp_hold_sel", 128'(quadrantSel), 128'(2'd1));
        end
        rowReady = 1'b1;
        tick();
        check("bp_release", 128'(rowValid), 128'(1'b0));
        check("bp_busy",    128'(busy),     128'(1'b0));

        // Request change during SETTLE: A keeps the grant, D is next
        req = 4'b0001; rowIn = 105'hA;
        tick();
        check("chg_sel_a", 128'(quadrantSel), 128'(2'd0));
        req = 4'b1000; rowIn = 105'hD;
        tick();
        tick();
        check("chg_ack_a", 128'(ack),    128'(4'b0001));
        check("chg_row_a", 128'(rowOut), 128'(105'hD));
        tick();
        check("chg_idle",  128'(busy),   128'(1'b0));
        tick();
        check("chg_sel_d", 128'(quadrantSel), 128'(2'd3));
        tick();
        tick();
        check("chg_ack_d", 128'(ack), 128'(4'b1000));
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset while holding an unconsumed row
        req = 4'b0100; rowReady = 1'b0; rowIn = 105'h77;
        tick();
        tick();
        tick();
        check("mid_vld", 128'(rowValid), 128'(1'b1));
        req = 4'b0000;
        tick();
        #1 rst = 1'b1;
        #1;
        check("arst_vld",  128'(rowValid),    128'(1'b0));
        check("arst_sel",  128'(quadrantSel), 128'(2'd0));
        check("arst_row",  128'(rowOut),      128'(0));
        check("arst_busy", 128'(busy),        128'(1'b0));
        check("arst_ack",  128'(ack),         128'(4'b0000));
        tick();
        check("arst_ack2", 128'(ack),         128'(4'b0000));
        rst = 1'b0;
        tick();

        // SETTLE_CYCLES=1 instance: capture on the edge after the grant edge
        req1 = 4'b0010; rowIn1 = 105'h55; rowReady1 = 1'b0;
        tick();
        check("s1_sel",  128'(quadrantSel1), 128'(2'd1));
        check("s1_vld0", 128'(rowValid1),    128'(1'b0));
        req1 = 4'b0000;
        tick();
        check("s1_vld1", 128'(rowValid1),    128'(1'b1));
        check("s1_ack",  128'(ack1),         128'(4'b0010));
        check("s1_row",  128'(rowOut1),      128'(105'h55));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
